// File: rtl/mouse_pos_readout.sv
// Samples the mouse position every refresh period and converts it to three BCD digits for the
// seven-segment driver; also stretches click/cheat pulses into LED levels.

module pulse_stretch #(
  parameter int HOLD_CYCLES = 33554432
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic led
);

  logic [25:0] stretch_cnt;

  // Retriggerable on-time counter; a new pulse always restarts the hold window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led         <= 1'b0;
      stretch_cnt <= 26'd0;
    end else if (pulse) begin
      led         <= 1'b1;
      stretch_cnt <= 26'd0;
    end else if (led) begin
      if (stretch_cnt == 26'(HOLD_CYCLES - 1)) begin
        led         <= 1'b0;
        stretch_cnt <= 26'd0;
      end else begin
        stretch_cnt <= stretch_cnt + 26'd1;
      end
    end else begin
      stretch_cnt <= 26'd0;
    end
  end

endmodule

module mouse_pos_readout #(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int HOLD_CYCLES    = 33554432
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [9:0]  mouse_x,
  input  logic [8:0]  mouse_y,
  input  logic        l_click,
  input  logic        cheat_activate,
  output logic [15:0] nums,
  output logic        click_led,
  output logic        cheat_led,
  output logic        busy
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] refresh_cnt;
  logic          tick;
  logic          sel_l;
  logic [9:0]    bin;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [3:0]    bit_cnt;
  logic [9:0]    raw_val;
  logic [9:0]    sat_val;

  assign tick = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

  // Free-running sample-period counter, independent of the converter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Input selection with saturation to the three-digit display range.
  always_comb begin
    raw_val = sel ? mouse_x : {1'b0, mouse_y};
    if (raw_val > 10'd999) begin
      sat_val = 10'd999;
    end else begin
      sat_val = raw_val;
    end
  end

  // Double-dabble correction: bump each digit >= 5 before it is shifted.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

  // Conversion FSM; nums is only written once the full result is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel_l   <= 1'b0;
      bin     <= 10'd0;
      bcd     <= 12'd0;
      bit_cnt <= 4'd0;
      nums    <= 16'h0000;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            sel_l   <= sel;
            bin     <= sat_val;
            bcd     <= 12'd0;
            bit_cnt <= 4'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          bit_cnt    <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            state <= DONE;
          end
        end
        DONE: begin
          nums  <= {3'b000, sel_l, bcd};
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  pulse_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_click_stretch (
    .clk   (clk),
    .rst   (rst),
    .pulse (l_click),
    .led   (click_led)
  );

  pulse_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_cheat_stretch (
    .clk   (clk),
    .rst   (rst),
    .pulse (cheat_activate),
    .led   (cheat_led)
  );

endmodule

// File: tb/tb_mouse_pos_readout.sv
// Directed bench for mouse_pos_readout with a 16-cycle refresh period and 8-cycle LED hold.

module tb_mouse_pos_readout;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [9:0]  mouse_x;
  logic [8:0]  mouse_y;
  logic        l_click;
  logic        cheat_activate;
  logic [15:0] nums;
  logic        click_led;
  logic        cheat_led;
  logic        busy;

  int          checks;
  int          fails;
  int          cyc;
  logic [15:0] prev_nums;

  mouse_pos_readout #(.REFRESH_CYCLES(16), .HOLD_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .sel            (sel),
    .mouse_x        (mouse_x),
    .mouse_y        (mouse_y),
    .l_click        (l_click),
    .cheat_activate (cheat_activate),
    .nums           (nums),
    .click_led      (click_led),
    .cheat_led      (cheat_led),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; tick edges are the multiples of 16.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Leaves the bench at the negedge of the cycle whose closing edge is a tick.
  task automatic wait_pre_tick(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((cyc % 16) != 15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((cyc % 16) != 15) begin
      fails++;
      $display("FAIL %s tick_wait: timed out after %0d cycles, cyc=%0d", name, n, cyc);
    end
  endtask

  task automatic convert(input logic s, input logic [9:0] x, input logic [8:0] y,
                         input logic [15:0] expected, input int mid, input logic ms,
                         input logic [9:0] mx, input logic [8:0] my, input string name);
    int          busy_cnt;
    logic        held_ok;
    logic [15:0] bad_val;
    wait_pre_tick(name);
    sel = s; mouse_x = x; mouse_y = y;
    busy_cnt = 0;
    held_ok  = 1'b1;
    bad_val  = prev_nums;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == mid) begin
        sel = ms; mouse_x = mx; mouse_y = my;
      end
      if (busy === 1'b1) busy_cnt++;
      if (nums !== prev_nums) begin
        held_ok = 1'b0;
        bad_val = nums;
      end
    end
    checks++;
    if (!held_ok) begin
      fails++;
      $display("FAIL %s nums_hold: saw %h during conversion, required %h", name, bad_val, prev_nums);
    end
    checks++;
    if (busy_cnt !== 11) begin
      fails++;
      $display("FAIL %s busy_len: got %0d cycles, required 11", name, busy_cnt);
    end
    @(negedge clk);
    checks++;
    if (nums !== expected) begin
      fails++;
      $display("FAIL %s nums: got %h, required %h", name, nums, expected);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_end: got %b, required 0", name, busy);
    end
    prev_nums = expected;
  endtask

  task automatic test_reset();
    rst = 1'b0; sel = 1'b0; mouse_x = 10'd0; mouse_y = 9'd0;
    l_click = 1'b0; cheat_activate = 1'b0;
    #12;
    checks++;
    if (nums !== 16'h0000) begin fails++; $display("FAIL reset nums: got %h, required 0000", nums); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b, required 0", busy); end
    checks++;
    if (click_led !== 1'b0) begin fails++; $display("FAIL reset click_led: got %b, required 0", click_led); end
    checks++;
    if (cheat_led !== 1'b0) begin fails++; $display("FAIL reset cheat_led: got %b, required 0", cheat_led); end
    @(negedge clk);
    rst = 1'b1;
    prev_nums = 16'h0000;
  endtask

  task automatic test_convert_x();
    convert(1'b1, 10'd639, 9'd0, 16'h1639, -1, 1'b1, 10'd639, 9'd0, "x639");
  endtask

  task automatic test_convert_y();
    convert(1'b0, 10'd0, 9'd479, 16'h0479, -1, 1'b0, 10'd0, 9'd479, "y479");
    convert(1'b0, 10'd0, 9'd0,   16'h0000, -1, 1'b0, 10'd0, 9'd0,   "y0");
    convert(1'b0, 10'd0, 9'd5,   16'h0005, -1, 1'b0, 10'd0, 9'd5,   "y5");
  endtask

  task automatic test_saturation();
    convert(1'b1, 10'd1023, 9'd0, 16'h1999, -1, 1'b1, 10'd1023, 9'd0, "x1023");
    convert(1'b1, 10'd999,  9'd0, 16'h1999, -1, 1'b1, 10'd999,  9'd0, "x999");
    convert(1'b1, 10'd100,  9'd0, 16'h1100, -1, 1'b1, 10'd100,  9'd0, "x100");
  endtask

  task automatic test_in_flight();
    convert(1'b1, 10'd320, 9'd7, 16'h1320, 3, 1'b0, 10'd7, 9'd7, "inflight");
    convert(1'b0, 10'd7,   9'd7, 16'h0007, -1, 1'b0, 10'd7, 9'd7, "after_inflight");
  endtask

  // Clicks in cycles 0 and 5; cheat in cycle 5 and again on its terminal count in cycle 13.
  task automatic test_stretch();
    logic exp_click;
    logic exp_cheat;
    @(negedge clk);
    l_click = 1'b1; cheat_activate = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      exp_click = (k >= 1) && (k <= 13);
      exp_cheat = (k >= 6) && (k <= 21);
      checks++;
      if (click_led !== exp_click) begin
        fails++;
        $display("FAIL stretch click_led cycle %0d: got %b, required %b", k, click_led, exp_click);
      end
      checks++;
      if (cheat_led !== exp_cheat) begin
        fails++;
        $display("FAIL stretch cheat_led cycle %0d: got %b, required %b", k, cheat_led, exp_cheat);
      end
      l_click        = (k == 5);
      cheat_activate = (k == 5) || (k == 13);
    end
    l_click = 1'b0; cheat_activate = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_pre_tick("reset_mid");
    sel = 1'b1; mouse_x = 10'd639; l_click = 1'b1;
    @(negedge clk);
    l_click = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, click_led} !== 2'b11) begin
      fails++;
      $display("FAIL reset_mid precondition busy/click_led: got %b, required 11", {busy, click_led});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (nums !== 16'h0000) begin fails++; $display("FAIL reset_mid nums: got %h, required 0000", nums); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid busy: got %b, required 0", busy); end
    checks++;
    if (click_led !== 1'b0) begin fails++; $display("FAIL reset_mid click_led: got %b, required 0", click_led); end
    @(negedge clk);
    rst = 1'b1;
    prev_nums = 16'h0000;
    convert(1'b1, 10'd639, 9'd0, 16'h1639, -1, 1'b1, 10'd639, 9'd0, "post_reset");
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    prev_nums = 16'h0000;
    test_reset();
    test_convert_x();
    test_convert_y();
    test_saturation();
    test_in_flight();
    test_stretch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
